// File: rtl/pipe_seq_ctrl_if.sv
// Handshake bundle between the PEECC run controller and its master.
// Master drives run control; slave (controller) drives stage enables/strobes.
interface pipe_seq_ctrl_if #(
  parameter int NUM_STAGES = 5,
  parameter int CNT_W      = 11
);
  localparam int SW = $clog2(NUM_STAGES);

  logic                  valid_in;
  logic                  fast_mode;
  logic [CNT_W-1:0]      dwell;
  logic                  abort;
  logic                  tx_finish;
  logic [NUM_STAGES-1:0] stage_en;
  logic [SW-1:0]         stage_idx;
  logic                  inn_rst_n;
  logic                  trigger;
  logic                  start_tx;
  logic                  done;
  logic                  busy;
  logic                  tx_timeout;

  modport master (
    output valid_in, fast_mode, dwell, abort, tx_finish,
    input  stage_en, stage_idx, inn_rst_n, trigger,
    input  start_tx, done, busy, tx_timeout
  );

  modport slave (
    input  valid_in, fast_mode, dwell, abort, tx_finish,
    output stage_en, stage_idx, inn_rst_n, trigger,
    output start_tx, done, busy, tx_timeout
  );
endinterface

// File: rtl/pipe_seq_ctrl.sv
// PEECC pipeline bring-up sequencer: staged fill, trigger window, TX handoff.
// Optional WAIT_TX watchdog enabled by defining PEECC_TX_TIMEOUT_EN.
module pipe_seq_ctrl #(
  parameter int NUM_STAGES = 5,
  parameter int CNT_W      = 11,
  parameter int TRIG_LO    = 1,
  parameter int TRIG_HI    = 9,
  parameter int TX_TIMEOUT = 4096
) (
  input logic           clk,
  input logic           rst,
  pipe_seq_ctrl_if.slave bus
);
  localparam int SW = $clog2(NUM_STAGES);
  localparam logic [SW-1:0] LAST = SW'(NUM_STAGES - 1);

  if (NUM_STAGES < 2 || TRIG_LO > TRIG_HI || TX_TIMEOUT < 1) begin : g_bad_cfg
    $error("pipe_seq_ctrl: illegal parameter set");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_WAIT
  } state_t;

  state_t                state;
  state_t                nxt_state;
  logic [SW-1:0]         idx;
  logic [SW-1:0]         nxt_idx;
  logic [CNT_W-1:0]      cnt;
  logic [CNT_W-1:0]      nxt_cnt;
  logic [CNT_W-1:0]      dm1;
  logic [CNT_W-1:0]      nxt_dm1;
  logic [NUM_STAGES-1:0] nxt_en;
  logic                  nxt_trig;
  logic                  nxt_pulse;
  logic                  nxt_tmo;

`ifdef PEECC_TX_TIMEOUT_EN
  localparam int TW = (TX_TIMEOUT > 1) ? $clog2(TX_TIMEOUT) : 1;
  logic [TW-1:0] wcnt;
  logic [TW-1:0] nxt_wcnt;
  logic          expiry;
  assign expiry = (wcnt == TW'(TX_TIMEOUT - 1));
`endif

  always_comb begin
    nxt_state = state;
    nxt_idx   = idx;
    nxt_cnt   = cnt;
    nxt_dm1   = dm1;
    nxt_tmo   = 1'b0;
`ifdef PEECC_TX_TIMEOUT_EN
    nxt_wcnt  = '0;
`endif
    unique case (state)
      S_IDLE: begin
        if (bus.valid_in) begin
          nxt_state = S_RUN;
          nxt_idx   = bus.fast_mode ? LAST : '0;
          nxt_cnt   = '0;
          nxt_dm1   = (bus.dwell == '0) ? '0 : bus.dwell - 1'b1;
        end
      end
      S_RUN: begin
        if (bus.abort) begin
          nxt_state = S_IDLE;
          nxt_idx   = '0;
          nxt_cnt   = '0;
        end else if (cnt == dm1) begin
          nxt_cnt = '0;
          if (idx == LAST) begin
            nxt_state = S_WAIT;
            nxt_idx   = '0;
          end else begin
            nxt_idx = idx + 1'b1;
          end
        end else begin
          nxt_cnt = cnt + 1'b1;
        end
      end
      S_WAIT: begin
        if (bus.abort || bus.tx_finish) begin
          nxt_state = S_IDLE;
`ifdef PEECC_TX_TIMEOUT_EN
        end else if (expiry) begin
          nxt_state = S_IDLE;
          nxt_tmo   = 1'b1;
        end else begin
          nxt_wcnt = wcnt + 1'b1;
`endif
        end
      end
      default: begin
        nxt_state = S_IDLE;
        nxt_idx   = '0;
        nxt_cnt   = '0;
      end
    endcase
  end

  // Outputs are registered from next-state so they align with the state.
  always_comb begin
    nxt_en = '0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      nxt_en[i] = (nxt_state == S_RUN) && (i <= int'(nxt_idx));
    end
    nxt_trig = (nxt_state == S_RUN) && (nxt_idx == LAST)
            && (nxt_cnt >= CNT_W'(TRIG_LO))
            && (nxt_cnt <= CNT_W'(TRIG_HI));
    nxt_pulse = (state == S_RUN) && (nxt_state == S_WAIT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      idx           <= '0;
      cnt           <= '0;
      dm1           <= '0;
      bus.stage_en  <= '0;
      bus.inn_rst_n <= 1'b0;
      bus.busy      <= 1'b0;
      bus.trigger   <= 1'b0;
      bus.start_tx  <= 1'b0;
      bus.done      <= 1'b0;
`ifdef PEECC_TX_TIMEOUT_EN
      wcnt           <= '0;
      bus.tx_timeout <= 1'b0;
`endif
    end else begin
      state         <= nxt_state;
      idx           <= nxt_idx;
      cnt           <= nxt_cnt;
      dm1           <= nxt_dm1;
      bus.stage_en  <= nxt_en;
      bus.inn_rst_n <= (nxt_state != S_IDLE);
      bus.busy      <= (nxt_state != S_IDLE);
      bus.trigger   <= nxt_trig;
      bus.start_tx  <= nxt_pulse;
      bus.done      <= nxt_pulse;
`ifdef PEECC_TX_TIMEOUT_EN
      wcnt           <= nxt_wcnt;
      bus.tx_timeout <= nxt_tmo;
`endif
    end
  end

`ifndef PEECC_TX_TIMEOUT_EN
  assign bus.tx_timeout = nxt_tmo;
`endif

  assign bus.stage_idx = idx;
endmodule
